// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the fetch stage: FSM states, pc_sel codes and reset defaults.
package pc_fetch_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

    localparam logic [1:0] PC_P4  = 2'd0;
    localparam logic [1:0] PC_ALU = 2'd1;
    localparam logic [1:0] PC_OLD = 2'd2;
    localparam logic [1:0] PC_M4  = 2'd3;

    typedef enum logic [1:0] {
        S_RST  = 2'b00,
        S_FILL = 2'b01,
        S_RUN  = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_if.sv
// Fetch-stage bus: ctrl/alu/imem inputs and PC/IR outputs.
// FETCH_PERF_EN adds the three performance counter outputs.
interface pc_fetch_if #(parameter int XLEN = 32);

    logic [1:0]      pc_sel;
    logic [XLEN-1:0] alu_out;
    logic            bubble;
    logic [XLEN-1:0] imem_rdata;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_p4;
    logic [XLEN-1:0] inst;
    logic [4:0]      opcode;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            inst_valid;
`ifdef FETCH_PERF_EN
    logic [31:0]     perf_cycles;
    logic [31:0]     perf_retired;
    logic [31:0]     perf_bubbles;
`endif

    modport master (
        input  pc_sel, alu_out, bubble, imem_rdata,
        output pc, pc_p4, inst, opcode, func3, func7, rd, rs1, rs2, inst_valid
`ifdef FETCH_PERF_EN
        , output perf_cycles, perf_retired, perf_bubbles
`endif
    );

    modport slave (
        output pc_sel, alu_out, bubble, imem_rdata,
        input  pc, pc_p4, inst, opcode, func3, func7, rd, rs1, rs2, inst_valid
`ifdef FETCH_PERF_EN
        , input perf_cycles, perf_retired, perf_bubbles
`endif
    );

endinterface

// File: rtl/pc_fetch_pc_reg.sv
// PC register with its next-value mux; only advances while the fetch FSM is running.
module pc_fetch_pc_reg
    import pc_fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_en,
    input  logic [1:0]      i_sel,
    input  logic [XLEN-1:0] i_alu_out,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_p4
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] w_pc_p4;
    logic            w_unused_alu_lsb;

    assign w_pc_p4          = r_pc + XLEN'(4);
    assign w_unused_alu_lsb = i_alu_out[0];

    // Jump targets are forced halfword-aligned; unknown codes fall back to sequential.
    always_comb begin
        w_pc_next = r_pc;
        if (i_en) begin
            case (i_sel)
                PC_P4:   w_pc_next = w_pc_p4;
                PC_ALU:  w_pc_next = {i_alu_out[XLEN-1:1], 1'b0};
                PC_OLD:  w_pc_next = r_pc;
                PC_M4:   w_pc_next = r_pc - XLEN'(4);
                default: w_pc_next = w_pc_p4;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_pc <= RESET_PC;
        else     r_pc <= w_pc_next;
    end

    assign o_pc    = r_pc;
    assign o_pc_p4 = w_pc_p4;

endmodule

// File: rtl/pc_fetch.sv
// Fetch stage: PC, instruction register, bubble injection and field slicing for ctrl.
// Define FETCH_PERF_EN to add cycle/retired/bubble counters.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
    input  logic       clk,
    input  logic       rst,
    pc_fetch_if.master fetch
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic [XLEN-1:0] r_inst;
    logic [XLEN-1:0] w_inst_next;
    logic            r_inst_valid;
    logic            w_inst_valid_next;
    logic            w_pc_en;
    logic [XLEN-1:0] w_pc;
    logic [XLEN-1:0] w_pc_p4;

    pc_fetch_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .i_en      (w_pc_en),
        .i_sel     (fetch.pc_sel),
        .i_alu_out (fetch.alu_out),
        .o_pc      (w_pc),
        .o_pc_p4   (w_pc_p4)
    );

    // S_FILL exists because the memory word seen right after reset belongs to no real fetch.
    always_comb begin
        w_state_next      = S_RST;
        w_inst_next       = NOP_INST;
        w_inst_valid_next = 1'b0;
        w_pc_en           = 1'b0;
        case (r_state)
            S_RST:  w_state_next = S_FILL;
            S_FILL: w_state_next = S_RUN;
            S_RUN: begin
                w_state_next      = S_RUN;
                w_pc_en           = 1'b1;
                w_inst_next       = fetch.bubble ? NOP_INST : fetch.imem_rdata;
                w_inst_valid_next = ~fetch.bubble;
            end
            default: w_state_next = S_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_RST;
            r_inst       <= NOP_INST;
            r_inst_valid <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_inst       <= w_inst_next;
            r_inst_valid <= w_inst_valid_next;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_cycles;
    logic [31:0] r_perf_retired;
    logic [31:0] r_perf_bubbles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_cycles  <= '0;
            r_perf_retired <= '0;
            r_perf_bubbles <= '0;
        end else if (r_state == S_RUN) begin
            r_perf_cycles  <= r_perf_cycles + 32'd1;
            r_perf_retired <= r_perf_retired + {31'd0, r_inst_valid};
            r_perf_bubbles <= r_perf_bubbles + {31'd0, fetch.bubble};
        end
    end

    assign fetch.perf_cycles  = r_perf_cycles;
    assign fetch.perf_retired = r_perf_retired;
    assign fetch.perf_bubbles = r_perf_bubbles;
`endif

    assign fetch.pc         = w_pc;
    assign fetch.pc_p4      = w_pc_p4;
    assign fetch.inst       = r_inst;
    assign fetch.inst_valid = r_inst_valid;
    assign fetch.opcode     = r_inst[6:2];
    assign fetch.func3      = r_inst[14:12];
    assign fetch.func7      = r_inst[31:25];
    assign fetch.rd         = r_inst[11:7];
    assign fetch.rs1        = r_inst[19:15];
    assign fetch.rs2        = r_inst[24:20];

endmodule
